// File: rtl/bcd_accumulator.sv
// bcd_accumulator: digit-serial BCD running-sum accumulator, carry ripples one digit per clock.
// Optional BCD_ACC_ERR_CHECK_EN: digits 10..15 are consumed and flagged in sticky err instead of clamped to 9.
module bcd_accumulator #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [3:0]            in_digit,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  err
);
    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    typedef enum logic {IDLE, ADD} state_t;
    state_t state_q, state_d;
    logic [4*DIGITS-1:0] sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0] op_q, op_d;
    logic carry_q, carry_d, done_q, done_d, ovf_q, ovf_d;
    logic [3:0] cur, addend, digit;
    logic [4:0] s;
    logic wrap;
`ifdef BCD_ACC_ERR_CHECK_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
    assign in_ready = (state_q == IDLE) && !clr && !rst;
    assign sum      = sum_q;
    assign busy     = (state_q == ADD);
    assign done     = done_q;
    assign overflow = ovf_q;
    // only the units digit receives the operand; higher digits see just the carry
    assign cur    = sum_q[4*idx_q +: 4];
    assign addend = (idx_q == '0) ? op_q : 4'd0;
    assign s      = {1'b0, cur} + {1'b0, addend} + {4'd0, carry_q};
    assign wrap   = s > 5'd9;
    assign digit  = wrap ? s[3:0] - 4'd10 : s[3:0];
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        op_d    = op_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
`ifdef BCD_ACC_ERR_CHECK_EN
        err_d   = err_q;
`endif
        if (clr) begin
            state_d = IDLE;
            sum_d   = '0;
            ovf_d   = 1'b0;
`ifdef BCD_ACC_ERR_CHECK_EN
            err_d   = 1'b0;
`endif
        end else if (state_q == IDLE) begin
            if (in_valid && in_ready) begin
`ifdef BCD_ACC_ERR_CHECK_EN
                if (in_digit > 4'd9) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ADD;
                    op_d    = in_digit;
                    idx_d   = '0;
                    carry_d = 1'b0;
                end
`else
                state_d = ADD;
                op_d    = (in_digit > 4'd9) ? 4'd9 : in_digit;
                idx_d   = '0;
                carry_d = 1'b0;
`endif
            end
        end else begin
            sum_d[4*idx_q +: 4] = digit;
            carry_d = wrap;
            idx_d   = idx_q + 1'b1;
            // a carry out of the top digit is dropped: the sum wraps modulo 10^DIGITS
            if (!wrap || idx_q == LAST) begin
                state_d = IDLE;
                done_d  = 1'b1;
                ovf_d   = ovf_q | wrap;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            idx_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef BCD_ACC_ERR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
`ifdef BCD_ACC_ERR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_bcd_accumulator.sv
// tb_bcd_accumulator: directed self-checking bench for bcd_accumulator with DIGITS=4.
module tb_bcd_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic [3:0] in_digit = 4'd0;
    logic in_ready, busy, done, overflow, err;
    logic [15:0] sum;
    int checks = 0;
    int errors = 0;

    bcd_accumulator #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_digit(in_digit),
        .in_ready(in_ready), .sum(sum), .busy(busy), .done(done), .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] bcd(int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic send(input logic [3:0] d, output int adds, output int dones);
        in_digit = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        adds = 0;
        while (busy && adds < 20) begin
            adds++;
            tick();
        end
        dones = int'(done);
        tick();
        dones += int'(done);
    endtask

    task automatic fill_nines(input int n);
        int a, d;
        do_reset();
        for (int i = 0; i < n; i++) send(4'd9, a, d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_digit = 4'd3;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h exp 0000", sum); end
        checks++; if ({busy, done, overflow, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, overflow, err}); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_basic();
        int a, d;
        do_reset();
        send(4'd7, a, d);
        checks++; if (a !== 1 || d !== 1) begin errors++; $display("FAIL add7 adds/dones got %0d/%0d exp 1/1", a, d); end
        checks++; if (sum !== 16'h0007) begin errors++; $display("FAIL add7_sum got %h exp 0007", sum); end
        send(4'd5, a, d);
        checks++; if (a !== 2 || d !== 1) begin errors++; $display("FAIL add5 adds/dones got %0d/%0d exp 2/1", a, d); end
        checks++; if (sum !== 16'h0012 || overflow !== 1'b0) begin errors++; $display("FAIL add5_sum got %h ovf %b exp 0012 ovf 0", sum, overflow); end
    endtask

    task automatic test_carry_chain();
        int a, d;
        fill_nines(111);
        checks++; if (sum !== 16'h0999) begin errors++; $display("FAIL fill999 got %h exp 0999", sum); end
        send(4'd1, a, d);
        checks++; if (a !== 4 || d !== 1) begin errors++; $display("FAIL chain adds/dones got %0d/%0d exp 4/1", a, d); end
        checks++; if (sum !== 16'h1000 || overflow !== 1'b0) begin errors++; $display("FAIL chain_sum got %h ovf %b exp 1000 ovf 0", sum, overflow); end
    endtask

    task automatic test_overflow();
        int a, d;
        fill_nines(1111);
        checks++; if (sum !== 16'h9999 || overflow !== 1'b0) begin errors++; $display("FAIL fill9999 got %h ovf %b exp 9999 ovf 0", sum, overflow); end
        send(4'd1, a, d);
        checks++; if (a !== 4 || d !== 1) begin errors++; $display("FAIL wrap adds/dones got %0d/%0d exp 4/1", a, d); end
        checks++; if (sum !== 16'h0000 || overflow !== 1'b1) begin errors++; $display("FAIL wrap_sum got %h ovf %b exp 0000 ovf 1", sum, overflow); end
        send(4'd3, a, d);
        checks++; if (sum !== 16'h0003 || overflow !== 1'b1) begin errors++; $display("FAIL sticky_ovf got %h ovf %b exp 0003 ovf 1", sum, overflow); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (sum !== 16'h0000 || overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %h ovf %b exp 0000 ovf 0", sum, overflow); end
    endtask

    task automatic test_clear_abort();
        fill_nines(111);
        in_digit = 4'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b exp 1", busy); end
        clr = 1'b1;
        in_valid = 1'b1;
        in_digit = 4'd5;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %b exp 0", in_ready); end
        tick();
        checks++; if (sum !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort got sum %h busy %b done %b exp 0000 0 0", sum, busy, done); end
        clr = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", in_ready); end
        tick();
        checks++; if (done !== 1'b0 || sum !== 16'h0000) begin errors++; $display("FAIL abort_after got done %b sum %h exp 0 0000", done, sum); end
    endtask

    task automatic test_back_to_back();
        int a, d, acc, dn, ex;
        logic r;
        do_reset();
        send(4'd1, a, d);
        for (int i = 0; i < 10; i++) send(4'd9, a, d);
        checks++; if (sum !== 16'h0091) begin errors++; $display("FAIL pre91 got %h exp 0091", sum); end
        acc = 0;
        dn = 0;
        ex = 91;
        in_digit = 4'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 10) in_valid = 1'b0;
            r = in_ready && in_valid;
            tick();
            acc += int'(r);
            if (done) begin
                dn++;
                ex += 9;
                checks++; if (sum !== bcd(ex)) begin errors++; $display("FAIL b2b_step got %h exp %h", sum, bcd(ex)); end
            end
        end
        checks++; if (acc !== 4 || dn !== 4) begin errors++; $display("FAIL b2b accepts/dones got %0d/%0d exp 4/4", acc, dn); end
        checks++; if (sum !== 16'h0127 || busy !== 1'b0) begin errors++; $display("FAIL b2b_final got %h busy %b exp 0127 0", sum, busy); end
    endtask

    task automatic test_illegal_digit();
        int a, d;
        do_reset();
        send(4'd5, a, d);
        send(4'd12, a, d);
`ifdef BCD_ACC_ERR_CHECK_EN
        checks++; if (a !== 0 || d !== 0) begin errors++; $display("FAIL illegal adds/dones got %0d/%0d exp 0/0", a, d); end
        checks++; if (sum !== 16'h0005 || err !== 1'b1) begin errors++; $display("FAIL illegal got sum %h err %b exp 0005 1", sum, err); end
`else
        checks++; if (a !== 2 || d !== 1) begin errors++; $display("FAIL clamp adds/dones got %0d/%0d exp 2/1", a, d); end
        checks++; if (sum !== 16'h0014 || err !== 1'b0) begin errors++; $display("FAIL clamp got sum %h err %b exp 0014 0", sum, err); end
`endif
    endtask

    task automatic test_reset_mid_add();
        fill_nines(111);
        in_digit = 4'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (sum !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid got sum %h busy %b done %b rdy %b exp 0000 0 0 0", sum, busy, done, in_ready); end
        rst = 1'b0;
        tick();
        checks++; if (done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_after got done %b rdy %b exp 0 1", done, in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_overflow();
        test_clear_abort();
        test_back_to_back();
        test_illegal_digit();
        test_reset_mid_add();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_accumulator.md
Name: bcd_accumulator

Overview:
- Digit-serial BCD accumulator sitting directly downstream of the single-digit BCD adder stage.
- Accepts a stream of BCD digits over a valid/ready handshake and adds each one into a DIGITS-wide packed BCD running sum.
- Carry ripples one decimal digit per clock.
- Output feeds display/readout logic; sum is always valid BCD.

Parameters:
- DIGITS, 4, number of BCD digits in the running sum (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- clr  input  1  synchronous clear of sum/flags; priority over everything except rst
- in_valid  input  1  in_digit valid this cycle
- in_digit  input  4  BCD digit to add (legal 0..9)
- in_ready  output  1  block can accept a digit this cycle
- sum  output  4*DIGITS  packed BCD running sum; digit 0 = sum[3:0] (units)
- busy  output  1  carry propagation in progress
- done  output  1  one-cycle pulse: an addition has completed
- overflow  output  1  sticky: sum wrapped past all-9s
- err  output  1  sticky: illegal digit received (see Optional Feature)

Behaviour:
- Clocking/reset: one clock domain (clk); rst synchronous, active-high.
- Reset values: sum=0, busy=0, done=0, overflow=0, err=0, state=IDLE. in_ready=0 while rst=1.
- in_ready is combinational: (state==IDLE) && !clr && !rst.
- Handshake: transfer when in_valid && in_ready. Holding in_valid while busy causes no extra accept.
- FSM states: IDLE, ADD.
- IDLE:
  - on transfer, latch operand=in_digit, idx=0, carry=0; go to ADD.
  - in_valid without in_ready is ignored.
- ADD, each cycle:
  - s = sum_digit[idx] + (idx==0 ? operand : 0) + carry (5-bit).
  - if s>9: digit=s-10, carry=1; else digit=s, carry=0.
  - write digit back to sum_digit[idx].
  - if new carry==0: return to IDLE (early exit).
  - else if idx==DIGITS-1: set overflow, discard carry (sum wraps modulo 10^DIGITS), return to IDLE.
  - else: idx=idx+1, stay in ADD.
- Latency: 1..DIGITS cycles in ADD per accepted digit. Minimum accept-to-accept spacing is 2 cycles.
- busy = (state==ADD).
- done is registered: high exactly one cycle, the first IDLE cycle after ADD exits. in_ready may also be 1 that cycle.
- sum updates digit by digit during ADD. It is guaranteed consistent only when busy=0.
- clr=1, any state: next cycle sum=0, overflow=0, err=0, done=0, state=IDLE. An in-progress ADD is aborted with no done pulse. A digit presented with clr=1 is not accepted.
- rst asserted mid-ADD behaves like clr: abort, all outputs to reset values.

Optional Feature:
- Macro: BCD_ACC_ERR_CHECK_EN.
- Defined:
  - in_digit 10..15 on a transfer is consumed (handshake completes) but not added.
  - FSM stays in IDLE; err is set sticky; no done pulse.
- Undefined:
  - err is tied 0.
  - in_digit 10..15 is clamped to 9 and added normally.

Test Plan (DIGITS=4):
- rst, then send 7 then 5 -> sum=0x0012. First add: 1 ADD cycle. Second: 2 ADD cycles (carry into tens). done pulses twice; overflow=0.
- Accumulate 111 digits of 9 (sum=0x0999), then send 1 -> 4 ADD cycles, sum=0x1000, done once, overflow=0.
- Accumulate 1111 digits of 9 (sum=0x9999), then send 1 -> 4 ADD cycles, sum=0x0000, overflow=1 and it stays 1. Then send 3 -> sum=0x0003, overflow still 1.
- At sum=0x0999, send 1; assert clr on the 2nd ADD cycle -> next cycle sum=0x0000, busy=0, no done, in_ready=1 after clr drops.
- in_valid held high for 10 cycles with in_digit=9 from sum=0x0091 -> accepts occur only when in_ready=1. After each done, sum advances by exactly 9 (0x0100, 0x0109, ...).
- in_digit=12 at sum=0x0005:
  - with BCD_ACC_ERR_CHECK_EN: sum=0x0005, err=1, no done.
  - without: sum=0x0014, err=0, done pulses.
